pw_checker: RTL and testbench



---
 rtl/pw_checker.sv | 135 +++++++++++++
 tb/tb_pw_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pw_checker.sv
`default_nettype none
// ============================================================================
// Module   : pw_checker
// Purpose  : Password compare FSM with wrong-guess counting and timed lockout.
// Revision : 1.0 - initial release
// ============================================================================
module pw_checker #(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] guess_pw,
    input  logic [15:0] actual_pw,
    input  logic        pw_set,
    input  logic        check,
    input  logic        relock,
    output logic        unlocked,
    output logic        wrong,
    output logic        locked_out,
    output logic [1:0]  attempts_left
);

    localparam int            C_CW        = $clog2(LOCKOUT_CYCLES) + 1;
    localparam logic [1:0]    C_MAX_ATT   = 2'(MAX_ATTEMPTS);
    localparam logic [C_CW-1:0] C_LOCK_LOAD = C_CW'(LOCKOUT_CYCLES - 1);

    localparam logic [2:0] C_IDLE     = 3'd0;
    localparam logic [2:0] C_COMPARE  = 3'd1;
    localparam logic [2:0] C_UNLOCKED = 3'd2;
    localparam logic [2:0] C_WRONG    = 3'd3;
    localparam logic [2:0] C_LOCKOUT  = 3'd4;

    logic [2:0]      state_q,      state_d;
    logic            check_q,      check_d;
    logic            arm_q,        arm_d;
    logic [15:0]     guess_q,      guess_d;
    logic [C_CW-1:0] cnt_q,        cnt_d;
    logic [1:0]      attempts_q,   attempts_d;
    logic            unlocked_q,   unlocked_d;
    logic            wrong_q,      wrong_d;
    logic            locked_out_q, locked_out_d;

    logic w_edge;

    // arm_q blocks a check level that was already high when reset released
    assign w_edge = check & ~check_q & arm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= C_IDLE;
            check_q      <= 1'b0;
            arm_q        <= 1'b0;
            guess_q      <= 16'h0000;
            cnt_q        <= '0;
            attempts_q   <= C_MAX_ATT;
            unlocked_q   <= 1'b0;
            wrong_q      <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            check_q      <= check_d;
            arm_q        <= arm_d;
            guess_q      <= guess_d;
            cnt_q        <= cnt_d;
            attempts_q   <= attempts_d;
            unlocked_q   <= unlocked_d;
            wrong_q      <= wrong_d;
            locked_out_q <= locked_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        check_d    = check;
        arm_d      = arm_q | ~check;
        guess_d    = guess_q;
        cnt_d      = cnt_q;
        attempts_d = attempts_q;
        case (state_q)
            C_IDLE: begin
                if (w_edge && pw_set) begin
                    guess_d = guess_pw;
                    state_d = C_COMPARE;
                end
            end
            C_COMPARE: begin
                if (guess_q == actual_pw) begin
                    attempts_d = C_MAX_ATT;
                    state_d    = C_UNLOCKED;
                end else if (attempts_q > 2'd1) begin
                    attempts_d = attempts_q - 2'd1;
                    state_d    = C_WRONG;
                end else begin
                    attempts_d = 2'd0;
                    cnt_d      = C_LOCK_LOAD;
                    state_d    = C_LOCKOUT;
                end
            end
            C_UNLOCKED: begin
                if (relock) begin
                    state_d = C_IDLE;
                end
            end
            C_WRONG: begin
                state_d = C_IDLE;
            end
            C_LOCKOUT: begin
                if (cnt_q == '0) begin
                    attempts_d = C_MAX_ATT;
                    state_d    = C_IDLE;
                end else begin
                    cnt_d = cnt_q - C_CW'(1);
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        unlocked_d   = (state_d == C_UNLOCKED);
        wrong_d      = (state_d == C_WRONG);
        locked_out_d = (state_d == C_LOCKOUT);
    end

    assign unlocked      = unlocked_q;
    assign wrong         = wrong_q;
    assign locked_out    = locked_out_q;
    assign attempts_left = attempts_q;

endmodule
`default_nettype wire

// File: tb/tb_pw_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pw_checker
// Purpose  : Directed table-driven bench for pw_checker (3 attempts, 8-cycle lockout).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pw_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] guess_pw;
    logic [15:0] actual_pw;
    logic        pw_set;
    logic        check;
    logic        relock;
    logic        unlocked;
    logic        wrong;
    logic        locked_out;
    logic [1:0]  attempts_left;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        c;
        logic        s;
        logic        r;
        logic [15:0] g;
        logic [15:0] a;
        logic        eu;
        logic        ew;
        logic        el;
        logic [1:0]  ea;
    } vec_t;

    vec_t vecs[$];

    pw_checker #(
        .MAX_ATTEMPTS  (3),
        .LOCKOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .guess_pw     (guess_pw),
        .actual_pw    (actual_pw),
        .pw_set       (pw_set),
        .check        (check),
        .relock       (relock),
        .unlocked     (unlocked),
        .wrong        (wrong),
        .locked_out   (locked_out),
        .attempts_left(attempts_left)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic add(input logic c, input logic s, input logic r,
                       input logic [15:0] g, input logic [15:0] a,
                       input logic eu, input logic ew, input logic el,
                       input logic [1:0] ea);
        vec_t v;
        v.c = c; v.s = s; v.r = r; v.g = g; v.a = a;
        v.eu = eu; v.ew = ew; v.el = el; v.ea = ea;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic eu, input logic ew,
                       input logic el, input logic [1:0] ea);
        checks++;
        if (unlocked !== eu || wrong !== ew || locked_out !== el || attempts_left !== ea) begin
            errors++;
            $display("FAIL %s: got unl=%b wr=%b lo=%b att=%0d, want unl=%b wr=%b lo=%b att=%0d",
                     nm, unlocked, wrong, locked_out, attempts_left, eu, ew, el, ea);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // correct guess, check edge ignored while unlocked, relock
        add(1,1,0,16'hFFFF,16'hFFFF, 0,0,0,3);
        add(1,1,0,16'hFFFF,16'hFFFF, 1,0,0,3);
        add(0,1,0,16'hFFFF,16'hFFFF, 1,0,0,3);
        add(1,1,0,16'hFFFF,16'hFFFF, 1,0,0,3);
        add(0,1,1,16'hFFFF,16'hFFFF, 0,0,0,3);
        add(0,1,0,16'hFFFF,16'hFFFF, 0,0,0,3);
        // guess changes after latch: compare uses the latched value
        add(1,1,0,16'h5A5A,16'h5A5A, 0,0,0,3);
        add(0,1,0,16'h0000,16'h5A5A, 1,0,0,3);
        add(0,1,1,16'h0000,16'h5A5A, 0,0,0,3);
        // first wrong guess; check rise during WRONG is ignored
        add(1,1,0,16'hAAAA,16'h0000, 0,0,0,3);
        add(0,1,0,16'hAAAA,16'h0000, 0,1,0,2);
        add(1,1,0,16'hAAAA,16'h0000, 0,0,0,2);
        add(1,1,0,16'hAAAA,16'h0000, 0,0,0,2);
        add(0,1,0,16'hAAAA,16'h0000, 0,0,0,2);
        // second wrong guess
        add(1,1,0,16'hAAAA,16'h0000, 0,0,0,2);
        add(0,1,0,16'hAAAA,16'h0000, 0,1,0,1);
        add(0,1,0,16'hAAAA,16'h0000, 0,0,0,1);
        // third wrong guess: no pulse, 8 cycles of lockout, check rise ignored
        add(1,1,0,16'hAAAA,16'h0000, 0,0,0,1);
        add(0,1,0,16'hAAAA,16'h0000, 0,0,1,0);
        add(0,1,0,16'hAAAA,16'h0000, 0,0,1,0);
        add(1,1,0,16'hAAAA,16'h0000, 0,0,1,0);
        add(1,1,0,16'hAAAA,16'h0000, 0,0,1,0);
        add(1,1,0,16'hAAAA,16'h0000, 0,0,1,0);
        add(1,1,0,16'hAAAA,16'h0000, 0,0,1,0);
        add(1,1,0,16'hAAAA,16'h0000, 0,0,1,0);
        add(1,1,0,16'hAAAA,16'h0000, 0,0,1,0);
        add(1,1,0,16'hAAAA,16'h0000, 0,0,0,3);
        add(1,1,0,16'hAAAA,16'h0000, 0,0,0,3);
        add(0,1,0,16'hAAAA,16'h0000, 0,0,0,3);
        add(0,1,0,16'hAAAA,16'h0000, 0,0,0,3);
        // pw_set low gates check edges, even with matching passwords
        add(1,0,0,16'h1234,16'h1234, 0,0,0,3);
        add(0,0,0,16'h1234,16'h1234, 0,0,0,3);
        add(1,0,0,16'h1234,16'h1234, 0,0,0,3);
        add(1,1,0,16'h1234,16'h1234, 0,0,0,3);
        add(0,1,0,16'h1234,16'h1234, 0,0,0,3);
        add(0,1,0,16'h1234,16'h1234, 0,0,0,3);

        reset = 1'b1; check = 1'b0; relock = 1'b0; pw_set = 1'b0;
        guess_pw = 16'h0000; actual_pw = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 0,0,0,2'd3);
        reset = 1'b0;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            check = vecs[i].c; pw_set = vecs[i].s; relock = vecs[i].r;
            guess_pw = vecs[i].g; actual_pw = vecs[i].a;
            step();
            chk($sformatf("vec%0d", i), vecs[i].eu, vecs[i].ew, vecs[i].el, vecs[i].ea);
        end

        // check held high across reset release is not an edge
        relock = 1'b0; pw_set = 1'b1; guess_pw = 16'hBEEF; actual_pw = 16'hBEEF;
        check = 1'b1; reset = 1'b1;
        step();
        chk("rst_check_high", 0,0,0,2'd3);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("held_high%0d", k), 0,0,0,2'd3);
        end
        check = 1'b0; step();
        check = 1'b1; step();
        chk("rearm_compare", 0,0,0,2'd3);
        step();
        chk("rearm_unlock", 1,0,0,2'd3);
        relock = 1'b1; check = 1'b0; step();
        chk("rearm_relock", 0,0,0,2'd3);
        relock = 1'b0;

        // reset during the 4th lockout cycle
        guess_pw = 16'hAAAA; actual_pw = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            check = 1'b1; step();
            check = 1'b0; step(); step();
        end
        check = 1'b1; step();
        check = 1'b0; step();
        step(); step(); step();
        chk("lockout_cycle4", 0,0,1,2'd0);
        #3 reset = 1'b1;
        #1;
        chk("rst_in_lockout", 0,0,0,2'd3);
        @(posedge clk);
        #1 reset = 1'b0;
        step(); step();
        chk("post_rst_lockout", 0,0,0,2'd3);

        // reset during COMPARE, after one wrong guess
        check = 1'b1; step();
        check = 1'b0; step();
        chk("pre_wrong", 0,1,0,2'd2);
        step();
        check = 1'b1; step();
        chk("in_compare", 0,0,0,2'd2);
        #2 reset = 1'b1;
        #1;
        chk("rst_in_compare", 0,0,0,2'd3);
        @(posedge clk);
        #1 reset = 1'b0;
        check = 1'b0;
        step(); step();
        chk("post_rst_compare", 0,0,0,2'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
